// File: rtl/dpr_pkg.sv
// dpr_pkg: shared types and helpers for the dpr_clr dual-port RAM.
//   dpr_state_t : clear sequencer state (CLEAR while filling, READY for user access)
//   dpr_depth() : number of words for a given address width
package dpr_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } dpr_state_t;

    function automatic int dpr_depth(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/dpr_core.sv
// dpr_core: bare single-clock true dual-port RAM, inferable as block RAM.
// Parameters: AW (address width, depth 2**AW), DW (data width).
// Ports:
//   clock        rising-edge clock
//   a1/d1/w1/q1  port 1 address, write data, write enable, read data
//   a2/d2/w2/q2  port 2 address, write data, write enable, read data
// Each port reads with one cycle of latency and is write-through on its own
// write. A port reading an address the other port writes on the same edge
// gets the old contents. On a same-address dual write port 2 wins.
// No reset: the array and read registers power up undefined.
module dpr_core
    import dpr_pkg::*;
#(
    parameter int AW = 14,
    parameter int DW = 8
) (
    input  logic          clock,
    input  logic [AW-1:0] a1,
    input  logic [DW-1:0] d1,
    input  logic          w1,
    output logic [DW-1:0] q1,
    input  logic [AW-1:0] a2,
    input  logic [DW-1:0] d2,
    input  logic          w2,
    output logic [DW-1:0] q2
);

    localparam int DEPTH = dpr_depth(AW);

    logic [DW-1:0] mem [DEPTH];

    // Both writes live in one process so the port-2 store, scheduled last,
    // overrides port 1 on a same-address collision.
    always_ff @(posedge clock) begin
        if (w1) begin
            mem[a1] <= d1;
        end
        if (w2) begin
            mem[a2] <= d2;
        end
        q1 <= w1 ? d1 : mem[a1];
        q2 <= w2 ? d2 : mem[a2];
    end

endmodule

// File: rtl/dpr_clr.sv
// dpr_clr: true dual-port RAM with a built-in clear sequencer.
// Parameters: AW (address width), DW (data width), CLRV (fill value).
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous active-low reset
//   a1/d1/w1/q1  port 1 address, write data, write enable, read data
//   a2/d2/w2/q2  port 2 address, write data, write enable, read data
//   clr          request a full clear (honoured only when ready)
//   ready        1 = ports accepted, 0 = clearing
//   coll         one-cycle pulse after a same-address dual write
// After reset, or on clr, every word is written with CLRV, one per edge,
// through port 1; user writes are dropped and q1/q2 read 0 meanwhile.
// Optional build macro DPR_OUTREG_EN adds an output register per port
// (read latency 2 instead of 1).
module dpr_clr
    import dpr_pkg::*;
#(
    parameter int            AW   = 14,
    parameter int            DW   = 8,
    parameter logic [DW-1:0] CLRV = '0
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [AW-1:0] a1,
    input  logic [DW-1:0] d1,
    input  logic          w1,
    output logic [DW-1:0] q1,
    input  logic [AW-1:0] a2,
    input  logic [DW-1:0] d2,
    input  logic          w2,
    output logic [DW-1:0] q2,
    input  logic          clr,
    output logic          ready,
    output logic          coll
);

    localparam int            DEPTH = dpr_depth(AW);
    localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

    dpr_state_t    state_reg;
    logic [AW-1:0] cnt_reg;
    logic          ready_reg;
    logic          coll_reg;
    logic          rd_ok_reg;

    logic          clearing;
    logic [AW-1:0] core_a1;
    logic [DW-1:0] core_d1;
    logic          core_w1;
    logic          core_w2;
    logic [DW-1:0] core_q1;
    logic [DW-1:0] core_q2;
    logic [DW-1:0] gated_q1;
    logic [DW-1:0] gated_q2;

    assign clearing = (state_reg == CLEAR);

    // Port 1 is borrowed by the sequencer while clearing; port 2 is idled.
    always_comb begin
        core_a1 = a1;
        core_d1 = d1;
        core_w1 = w1;
        core_w2 = w2;
        if (clearing) begin
            core_a1 = cnt_reg;
            core_d1 = CLRV;
            core_w1 = 1'b1;
            core_w2 = 1'b0;
        end
    end

    dpr_core #(
        .AW(AW),
        .DW(DW)
    ) u_core (
        .clock (clock),
        .a1    (core_a1),
        .d1    (core_d1),
        .w1    (core_w1),
        .q1    (core_q1),
        .a2    (a2),
        .d2    (d2),
        .w2    (core_w2),
        .q2    (core_q2)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= CLEAR;
            cnt_reg   <= '0;
            ready_reg <= 1'b0;
            coll_reg  <= 1'b0;
            rd_ok_reg <= 1'b0;
        end else begin
            // The core read registers hold a user read only if this edge
            // served the user; otherwise they carry clear write-through data.
            rd_ok_reg <= (state_reg == READY);
            case (state_reg)
                CLEAR: begin
                    coll_reg <= 1'b0;
                    cnt_reg  <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST) begin
                        state_reg <= READY;
                        ready_reg <= 1'b1;
                    end
                end
                READY: begin
                    coll_reg <= w1 && w2 && (a1 == a2);
                    if (clr) begin
                        state_reg <= CLEAR;
                        cnt_reg   <= '0;
                        ready_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= CLEAR;
                    cnt_reg   <= '0;
                    ready_reg <= 1'b0;
                    coll_reg  <= 1'b0;
                end
            endcase
        end
    end

    // rd_ok_reg is reset asynchronously, so q drops to 0 as soon as reset
    // asserts even though the core registers themselves are not reset.
    assign gated_q1 = rd_ok_reg ? core_q1 : '0;
    assign gated_q2 = rd_ok_reg ? core_q2 : '0;

`ifdef DPR_OUTREG_EN
    logic [DW-1:0] q1_reg;
    logic [DW-1:0] q2_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q1_reg <= '0;
            q2_reg <= '0;
        end else begin
            q1_reg <= gated_q1;
            q2_reg <= gated_q2;
        end
    end

    assign q1 = q1_reg;
    assign q2 = q2_reg;
`else
    assign q1 = gated_q1;
    assign q2 = gated_q2;
`endif

    assign ready = ready_reg;
    assign coll  = coll_reg;

endmodule

// File: tb/tb_dpr_clr.sv
// tb_dpr_clr: randomized scoreboard bench for dpr_clr (AW=4, DW=8, CLRV=A5).
// The stimulus task updates a word-array reference model and queues the
// expected q1/q2/ready/coll values with the cycle they are due; a monitor
// on the falling edge pops due entries and compares them with the DUT.
module tb_dpr_clr;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam logic [7:0] CLRV = 8'hA5;
`ifdef DPR_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] a1 = '0;
    logic [DW-1:0] d1 = '0;
    logic          w1 = 1'b0;
    logic [DW-1:0] q1;
    logic [AW-1:0] a2 = '0;
    logic [DW-1:0] d2 = '0;
    logic          w2 = 1'b0;
    logic [DW-1:0] q2;
    logic          clr = 1'b0;
    logic          ready;
    logic          coll;

    dpr_clr #(
        .AW(AW),
        .DW(DW),
        .CLRV(CLRV)
    ) dut (
        .clock (clock),
        .reset (reset),
        .a1    (a1),
        .d1    (d1),
        .w1    (w1),
        .q1    (q1),
        .a2    (a2),
        .d2    (d2),
        .w2    (w2),
        .q2    (q2),
        .clr   (clr),
        .ready (ready),
        .coll  (coll)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         due;
        int         kind;   // 0 q1, 1 q2, 2 ready, 3 coll
        logic [7:0] exp;
    } exp_t;

    exp_t       sbq[$];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    logic [7:0] mem_m [DEPTH];
    int         clr_left;   // clear edges still to go; 0 means READY

    always @(posedge clock) cyc++;

    function automatic string kind_name(input int k);
        case (k)
            0:       return "q1";
            1:       return "q2";
            2:       return "ready";
            default: return "coll";
        endcase
    endfunction

    function automatic logic [7:0] dut_val(input int k);
        case (k)
            0:       return q1;
            1:       return q2;
            2:       return {7'd0, ready};
            default: return {7'd0, coll};
        endcase
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compare every expectation that falls due on this cycle.
    always @(negedge clock) begin
        int i;
        i = 0;
        while (i < sbq.size()) begin
            if (sbq[i].due == cyc) begin
                chk(kind_name(sbq[i].kind), dut_val(sbq[i].kind), sbq[i].exp);
                sbq.delete(i);
            end else if (sbq[i].due < cyc) begin
                checks++;
                failures++;
                $display("FAIL missed_%s due=%0d cyc=%0d", kind_name(sbq[i].kind), sbq[i].due, cyc);
                sbq.delete(i);
            end else begin
                i++;
            end
        end
    end

    function automatic void push(input int due, input int kind, input logic [7:0] exp);
        exp_t e;
        e.due  = due;
        e.kind = kind;
        e.exp  = exp;
        sbq.push_back(e);
    endfunction

    // One clock of stimulus; called at a falling edge, returns at the next one.
    task automatic step(input int x1, input int e1, input int v1,
                        input int x2, input int e2, input int v2, input int c);
        logic [7:0] r1, r2, ec;
        a1  = x1[AW-1:0];
        d1  = e1[7:0];
        w1  = v1[0];
        a2  = x2[AW-1:0];
        d2  = e2[7:0];
        w2  = v2[0];
        clr = c[0];
        $display("txn cyc=%0d a1=%h d1=%h w1=%0d a2=%h d2=%h w2=%0d clr=%0d",
                 cyc, a1, d1, w1, a2, d2, w2, clr);
        ec = 8'd0;
        if (clr_left == 0) begin
            r1 = w1 ? d1 : mem_m[a1];
            r2 = w2 ? d2 : mem_m[a2];
            if (w1) mem_m[a1] = d1;
            if (w2) mem_m[a2] = d2;
            if (w1 && w2 && a1 == a2) ec = 8'd1;
            if (clr) clr_left = DEPTH;
        end else begin
            r1 = 8'd0;
            r2 = 8'd0;
            clr_left--;
            if (clr_left == 0) begin
                for (int k = 0; k < DEPTH; k++) mem_m[k] = CLRV;
            end
        end
        push(cyc + LAT, 0, r1);
        push(cyc + LAT, 1, r2);
        push(cyc + 1, 2, {7'd0, clr_left == 0});
        push(cyc + 1, 3, ec);
        @(negedge clock);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic read_all();
        for (int k = 0; k < DEPTH; k++) step(k, 0, 0, DEPTH - 1 - k, 0, 0, 0);
    endtask

    // Reset asserted at a falling edge; outputs must drop at once.
    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_q1", q1, 8'd0);
        chk("rst_q2", q2, 8'd0);
        chk("rst_ready", {7'd0, ready}, 8'd0);
        chk("rst_coll", {7'd0, coll}, 8'd0);
        sbq.delete();
        clr_left = DEPTH;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int guard;
        clr_left = DEPTH;
        for (int k = 0; k < DEPTH; k++) mem_m[k] = 8'hXX;

        // Power-on reset state.
        @(negedge clock);
        #1;
        chk("por_q1", q1, 8'd0);
        chk("por_q2", q2, 8'd0);
        chk("por_ready", {7'd0, ready}, 8'd0);
        chk("por_coll", {7'd0, coll}, 8'd0);
        @(negedge clock);
        reset = 1'b1;

        // Initial clear with random port traffic that must be dropped.
        for (int k = 0; k < DEPTH; k++)
            step($urandom_range(0, 15), $urandom_range(0, 255), 1,
                 $urandom_range(0, 15), $urandom_range(0, 255), 1, 1);
        read_all();

        // Write on port 1, then read it back on port 2.
        step(5, 8'h3C, 1, 0, 0, 0, 0);
        step(0, 0, 0, 5, 0, 0, 0);

        // Same-address dual write: port 2 wins, coll pulses.
        step(7, 8'h11, 1, 7, 8'h22, 1, 0);
        idle();
        step(7, 0, 0, 7, 0, 0, 0);
        step(7, 8'h33, 1, 8, 8'h44, 1, 0);

        // Cross-port read of a word being written returns old data.
        step(9, 8'h55, 1, 9, 0, 0, 0);
        step(0, 0, 0, 9, 0, 0, 0);

        // clr with a concurrent write, random writes during the clear.
        step(2, 8'h77, 1, 3, 0, 0, 1);
        for (int k = 0; k < DEPTH; k++)
            step($urandom_range(0, 15), $urandom_range(0, 255), 1,
                 $urandom_range(0, 15), $urandom_range(0, 255), 1, 0);
        read_all();

        // Reset in the middle of a clear (counter = 6).
        step(0, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 6; k++) idle();
        do_reset();
        for (int k = 0; k < DEPTH; k++) idle();
        read_all();

        // Randomized traffic with occasional clears.
        for (int n = 0; n < 400; n++)
            step($urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 1),
                 $urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 1),
                 ($urandom_range(0, 39) == 0) ? 1 : 0);

        guard = 0;
        while (clr_left != 0 && guard < 2 * DEPTH) begin
            idle();
            guard++;
        end
        read_all();

        // Let the last expectations fall due, then the queue must be empty.
        w1 = 1'b0;
        w2 = 1'b0;
        clr = 1'b0;
        repeat (LAT + 2) @(negedge clock);
        chk("sb_drained", (sbq.size() == 0) ? 8'd1 : 8'd0, 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
